// File: rtl/shared_mem_xbar.sv
// -----------------------------------------------------------------------------
// shared_mem_xbar
//   Shared-memory crossbar between N_CORES requesting cores and N_BANKS
//   single-port word banks. Addresses are low-order interleaved across banks.
//   Each bank runs its own round-robin arbiter. A read-only winner can pull
//   along every other eligible read-only request to the identical address
//   (coalescing, COALESCE=1). Completion is a one-cycle `finish` pulse one
//   cycle after the request is sampled, with load data on the per-core lane.
//
// Ports
//   clk       in   single clock, rising edge
//   reset     in   asynchronous, active-high
//   read      in   [N_CORES]          per-core load request, held until finish
//   write     in   [N_CORES]          per-core store request, held until finish
//   addr_in   in   [N_CORES*ADDR_W]   core i word address at [i*ADDR_W +: ADDR_W]
//   data_in   in   [N_CORES*DATA_W]   core i store data at [i*DATA_W +: DATA_W]
//   data_out  out  [N_CORES*DATA_W]   core i load data, updated only with finish[i]
//   finish    out  [N_CORES]          one-cycle completion pulse per core
// -----------------------------------------------------------------------------
module shared_mem_xbar #(
  parameter int N_CORES  = 16,
  parameter int N_BANKS  = 16,
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 8,
  parameter int COALESCE = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_CORES-1:0]         read,
  input  logic [N_CORES-1:0]         write,
  input  logic [N_CORES*ADDR_W-1:0]  addr_in,
  input  logic [N_CORES*DATA_W-1:0]  data_in,
  output logic [N_CORES*DATA_W-1:0]  data_out,
  output logic [N_CORES-1:0]         finish
);

  localparam int BANK_W = $clog2(N_BANKS);
  localparam int WORD_W = ADDR_W - BANK_W;
  localparam int DEPTH  = 1 << WORD_W;
  localparam int CORE_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  logic [ADDR_W-1:0] addr_a  [N_CORES];
  logic [DATA_W-1:0] wdata_a [N_CORES];
  logic [BANK_W-1:0] bank_a  [N_CORES];
  logic [WORD_W-1:0] word_a  [N_CORES];
  logic [N_CORES-1:0] elig;

  for (genvar i = 0; i < N_CORES; i++) begin : g_unpack
    assign addr_a[i]  = addr_in[i*ADDR_W +: ADDR_W];
    assign wdata_a[i] = data_in[i*DATA_W +: DATA_W];
    assign bank_a[i]  = addr_a[i][BANK_W-1:0];
    assign word_a[i]  = addr_a[i][ADDR_W-1:BANK_W];
  end

  // A core whose finish is high this cycle is masked, so one access can
  // never be granted twice off the same held request.
  assign elig = (read | write) & ~finish;

  logic [N_BANKS-1:0][CORE_W-1:0] rr_ptr;
  logic [N_BANKS-1:0]             gnt_vld_p0;
  logic [N_BANKS-1:0][CORE_W-1:0] gnt_idx_p0;
  logic [N_CORES-1:0]             fin_p0;
  logic [DATA_W-1:0]              rdata_p0 [N_BANKS];

  // ---- Stage p0: per-bank round-robin arbitration -------------------------
  always_comb begin
    logic [CORE_W:0]   sum;
    logic [CORE_W-1:0] cand;
    logic              hit;
    sum  = '0;
    cand = '0;
    hit  = 1'b0;
    for (int b = 0; b < N_BANKS; b++) begin
      hit           = 1'b0;
      gnt_vld_p0[b] = 1'b0;
      gnt_idx_p0[b] = '0;
      for (int k = 0; k < N_CORES; k++) begin
        // Candidate index rr_ptr+k wrapped modulo N_CORES (N_CORES need not
        // be a power of two, so wrap explicitly).
        sum = {1'b0, rr_ptr[b]} + (CORE_W+1)'(k);
        if (sum >= (CORE_W+1)'(N_CORES))
          sum = sum - (CORE_W+1)'(N_CORES);
        cand = sum[CORE_W-1:0];
        if (!hit && elig[cand] && (bank_a[cand] == BANK_W'(b))) begin
          hit           = 1'b1;
          gnt_vld_p0[b] = 1'b1;
          gnt_idx_p0[b] = cand;
        end
      end
    end
  end

  // Completion set: each bank's winner, plus (read-only winners only) every
  // eligible read-only core on the very same address. Such cores are
  // necessarily in the same bank, so they share the winner's read data.
  always_comb begin
    fin_p0 = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      if (gnt_vld_p0[b]) begin
        fin_p0[gnt_idx_p0[b]] = 1'b1;
        if ((COALESCE != 0) && !write[gnt_idx_p0[b]]) begin
          for (int i = 0; i < N_CORES; i++) begin
            if (elig[i] && read[i] && !write[i] &&
                (addr_a[i] == addr_a[gnt_idx_p0[b]]))
              fin_p0[i] = 1'b1;
          end
        end
      end
    end
  end

  // ---- Stage p0 -> p1: bank storage ---------------------------------------
  // Read data is taken combinationally from the array and registered at the
  // same edge that commits a write, so a read+write winner sees the old word.
  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    logic [DATA_W-1:0] mem [DEPTH];

    assign rdata_p0[b] = mem[word_a[gnt_idx_p0[b]]];

    always_ff @(posedge clk) begin
      if (!reset && gnt_vld_p0[b] && write[gnt_idx_p0[b]])
        mem[word_a[gnt_idx_p0[b]]] <= wdata_a[gnt_idx_p0[b]];
    end
  end

  // ---- Stage p1: registered completion, load data and arbiter pointers ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      finish   <= '0;
      data_out <= '0;
      rr_ptr   <= '0;
    end else begin
      finish <= fin_p0;
      for (int i = 0; i < N_CORES; i++) begin
        if (fin_p0[i])
          data_out[i*DATA_W +: DATA_W] <= rdata_p0[bank_a[i]];
      end
      // Only the true winner moves the pointer; coalesced cores do not.
      for (int b = 0; b < N_BANKS; b++) begin
        if (gnt_vld_p0[b])
          rr_ptr[b] <= (gnt_idx_p0[b] == CORE_W'(N_CORES-1)) ? '0
                                                             : gnt_idx_p0[b] + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_shared_mem_xbar.sv
// -----------------------------------------------------------------------------
// tb_shared_mem_xbar
//   Self-checking bench for shared_mem_xbar (16 cores, 16 banks, 12-bit
//   addresses, 8-bit data, coalescing enabled). A behavioural model keeps a
//   flat word memory, one round-robin pointer per bank and per-core request
//   records; every cycle it predicts the finish vector and load data lanes.
//   Directed scenarios are followed by randomized held-request traffic.
// -----------------------------------------------------------------------------
module tb_shared_mem_xbar;

  localparam int NC = 16;
  localparam int NB = 16;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int CO = 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [NC-1:0]     read, write, finish;
  logic [NC*AW-1:0]  addr_in;
  logic [NC*DW-1:0]  data_in, data_out;

  always #5 clk = ~clk;

  shared_mem_xbar #(
    .N_CORES(NC), .N_BANKS(NB), .ADDR_W(AW), .DATA_W(DW), .COALESCE(CO)
  ) dut (
    .clk(clk), .reset(reset), .read(read), .write(write),
    .addr_in(addr_in), .data_in(data_in), .data_out(data_out), .finish(finish)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Per-core outstanding request as the cores see it.
  bit         rq_rd   [NC];
  bit         rq_wr   [NC];
  int         rq_addr [NC];
  logic [7:0] rq_data [NC];

  // Reference model state.
  logic [7:0]    m_mem   [1<<AW];
  bit            m_known [1<<AW];
  int            m_rr    [NB];
  logic [NC-1:0] m_fin;
  logic [7:0]    m_dout  [NC];
  bit            m_dknown[NC];

  task automatic chk_eq(string tag, logic [127:0] got, logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NC; i++) begin
      logic [31:0] a;
      a = rq_addr[i];
      read[i]  = rq_rd[i];
      write[i] = rq_wr[i];
      addr_in[i*AW +: AW] = a[AW-1:0];
      data_in[i*DW +: DW] = rq_data[i];
    end
  endtask

  task automatic set_req(int i, bit rd, bit wr, int a, logic [7:0] d);
    rq_rd[i] = rd; rq_wr[i] = wr; rq_addr[i] = a; rq_data[i] = d;
  endtask

  task automatic clr_all();
    for (int i = 0; i < NC; i++) set_req(i, 0, 0, 0, 8'h00);
  endtask

  task automatic model_reset();
    m_fin = '0;
    for (int i = 0; i < NC; i++) begin m_dout[i] = 8'h00; m_dknown[i] = 1; end
    for (int b = 0; b < NB; b++) m_rr[b] = 0;
  endtask

  // One clock of the crossbar, stated directly from the rules: eligibility,
  // round-robin search from the bank pointer, coalescing of identical reads,
  // all reads seeing pre-edge memory contents, then writes committed.
  task automatic model_step();
    logic [NC-1:0] nf;
    bit            elig [NC];
    bit            we   [NB];
    int            wa   [NB];
    logic [7:0]    wd   [NB];
    int            win, j;
    nf = '0;
    for (int i = 0; i < NC; i++) elig[i] = (rq_rd[i] || rq_wr[i]) && !m_fin[i];
    for (int b = 0; b < NB; b++) begin
      we[b] = 0; wa[b] = 0; wd[b] = 8'h00;
      win = -1;
      for (int k = 0; k < NC; k++) begin
        j = (m_rr[b] + k) % NC;
        if (win < 0 && elig[j] && (rq_addr[j] % NB) == b) win = j;
      end
      if (win >= 0) begin
        nf[win]       = 1'b1;
        m_dout[win]   = m_mem[rq_addr[win]];
        m_dknown[win] = m_known[rq_addr[win]];
        m_rr[b]       = (win + 1) % NC;
        if (rq_wr[win]) begin
          we[b] = 1; wa[b] = rq_addr[win]; wd[b] = rq_data[win];
        end else if (CO != 0) begin
          for (int i = 0; i < NC; i++)
            if (i != win && elig[i] && rq_rd[i] && !rq_wr[i] && rq_addr[i] == rq_addr[win]) begin
              nf[i]       = 1'b1;
              m_dout[i]   = m_mem[rq_addr[win]];
              m_dknown[i] = m_known[rq_addr[win]];
            end
        end
      end
    end
    for (int b = 0; b < NB; b++)
      if (we[b]) begin m_mem[wa[b]] = wd[b]; m_known[wa[b]] = 1; end
    m_fin = nf;
  endtask

  // Drive, advance one edge, compare at the falling edge, retire finished
  // requests (cores drop a request once its finish is seen).
  task automatic cycle();
    drive();
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk_eq("finish", finish, m_fin);
    for (int i = 0; i < NC; i++)
      if (m_dknown[i]) chk_eq($sformatf("dout%0d", i), data_out[i*DW +: DW], m_dout[i]);
    for (int i = 0; i < NC; i++)
      if (m_fin[i]) begin rq_rd[i] = 0; rq_wr[i] = 0; end
  endtask

  task automatic do_reset();
    clr_all();
    drive();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int ord [4];
    for (int a = 0; a < (1<<AW); a++) begin m_mem[a] = 8'h00; m_known[a] = 0; end
    reset = 1'b1;
    clr_all();
    drive();
    model_reset();
    repeat (2) @(negedge clk);
    chk_eq("rst_finish", finish, 0);
    chk_eq("rst_dout", data_out, 0);
    reset = 1'b0;

    // Single access: write then read back through core 3.
    set_req(3, 0, 1, 'h012, 8'hA5);
    cycle();
    chk_eq("t1_wr_fin", finish, 16'h0008);
    set_req(3, 1, 0, 'h012, 8'h00);
    cycle();
    chk_eq("t1_mask", finish, 16'h0000);
    cycle();
    chk_eq("t1_rd_fin", finish, 16'h0008);
    chk_eq("t1_rd_data", data_out[3*DW +: DW], 8'hA5);

    // Bank conflict on bank 4 straight after reset.
    do_reset();
    set_req(0, 1, 0, 'h004, 0);
    set_req(1, 1, 0, 'h014, 0);
    set_req(2, 1, 0, 'h024, 0);
    set_req(5, 1, 0, 'h054, 0);
    ord[0] = 0; ord[1] = 1; ord[2] = 2; ord[3] = 5;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk_eq($sformatf("t2_order%0d", k), finish, 128'(1) << ord[k]);
    end
    // Pointer of bank 4 now sits at 6: core 7 beats core 0.
    set_req(0, 1, 0, 'h064, 0);
    set_req(7, 1, 0, 'h074, 0);
    cycle();
    chk_eq("t2_rr_first", finish, 16'h0080);
    cycle();
    chk_eq("t2_rr_second", finish, 16'h0001);

    // Coalescing: core 3 moves bank 3's pointer to 4, then core 4's write wins
    // and the three identical reads complete together with the new data.
    set_req(3, 0, 1, 'h0F3, 8'h77);
    cycle();
    chk_eq("t3_pre", finish, 16'h0008);
    set_req(2, 1, 0, 'h0F3, 0);
    set_req(7, 1, 0, 'h0F3, 0);
    set_req(9, 1, 0, 'h0F3, 0);
    set_req(4, 0, 1, 'h0F3, 8'h5A);
    cycle();
    chk_eq("t3_write_first", finish, 16'h0010);
    cycle();
    chk_eq("t3_coalesced", finish, 16'h0284);
    chk_eq("t3_data7", data_out[7*DW +: DW], 8'h5A);
    chk_eq("t3_data2", data_out[2*DW +: DW], 8'h5A);
    cycle();

    // Parallel banks: one core per bank.
    for (int i = 0; i < NC; i++) set_req(i, 0, 1, i, 8'(i*7 + 1));
    cycle();
    chk_eq("t4_par_wr", finish, 16'hFFFF);
    for (int i = 0; i < NC; i++) set_req(i, 1, 0, i, 8'h00);
    cycle();
    chk_eq("t4_mask", finish, 16'h0000);
    cycle();
    chk_eq("t4_par_rd", finish, 16'hFFFF);
    chk_eq("t4_data5", data_out[5*DW +: DW], 8'h24);
    cycle();

    // Read+write together returns the old word.
    set_req(1, 0, 1, 'h021, 8'h11);
    cycle();
    chk_eq("t5_init", finish, 16'h0002);
    set_req(1, 1, 1, 'h021, 8'h3C);
    cycle();
    cycle();
    chk_eq("t5_rw_fin", finish, 16'h0002);
    chk_eq("t5_rw_old", data_out[1*DW +: DW], 8'h11);
    set_req(1, 1, 0, 'h021, 8'h00);
    cycle();
    cycle();
    chk_eq("t5_rd_new", data_out[1*DW +: DW], 8'h3C);
    cycle();

    // Reset in the middle of bank-0 contention.
    set_req(0, 1, 0, 'h000, 0);
    set_req(5, 1, 0, 'h010, 0);
    set_req(9, 1, 0, 'h020, 0);
    set_req(12, 1, 0, 'h030, 0);
    cycle();
    cycle();
    reset = 1'b1;
    model_reset();
    #1;
    chk_eq("t6_async_fin", finish, 0);
    chk_eq("t6_async_dout", data_out, 0);
    @(posedge clk);
    @(negedge clk);
    chk_eq("t6_held_fin", finish, 0);
    chk_eq("t6_held_dout", data_out, 0);
    reset = 1'b0;
    clr_all();
    set_req(0, 1, 0, 'h000, 0);
    set_req(5, 1, 0, 'h010, 0);
    set_req(9, 1, 0, 'h020, 0);
    set_req(12, 1, 0, 'h030, 0);
    cycle();
    chk_eq("t6_restart", finish, 16'h0001);
    repeat (4) cycle();

    // Randomized held-request traffic over a small address window so that
    // bank conflicts and same-address coalescing happen often.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NC; i++) begin
        if (!(rq_rd[i] || rq_wr[i]) && $urandom_range(0, 2) == 0) begin
          int kind, a;
          kind = $urandom_range(0, 3);
          a    = $urandom_range(0, 3) * NB + $urandom_range(0, NB-1);
          set_req(i, kind != 2, kind >= 2, a, 8'($urandom));
        end
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
